// File: rtl/mux8way_stream.sv
// mux8way_stream: eight valid/ready producers arbitrated onto one registered output word tagged
// with its source channel. Define MUX8WAY_STREAM_ROUND_ROBIN_EN for rotating priority; otherwise
// the lowest-numbered valid channel always wins.
module mux8way_stream #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_select,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [2:0]       out_select_q, out_select_d;

  logic [2:0] search_base;
  logic       grant_found;
  logic [2:0] grant_idx;
  logic       can_accept;
  logic       transfer;

`ifdef MUX8WAY_STREAM_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;
  assign search_base = ptr_q;
`else
  assign search_base = 3'd0;
`endif

  // The output slot frees up in the same cycle it drains, so refill can overlap drain.
  assign can_accept = !out_valid_q || out_ready;

  // First valid channel at or after search_base, with 3-bit wraparound.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = search_base;
    for (int k = 0; k < 8; k++) begin
      if (!grant_found && in_valid[search_base + 3'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = search_base + 3'(k);
      end
    end
  end

  assign transfer = grant_found && can_accept;

  always_comb begin
    in_ready = 8'h00;
    if (reset_n && transfer) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_select_d = out_select_q;
    if (transfer) begin
      out_valid_d  = 1'b1;
      out_data_d   = in_data[32'(grant_idx) * WIDTH +: WIDTH];
      out_select_d = grant_idx;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_select_q <= 3'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_select_q <= out_select_d;
    end
  end

`ifdef MUX8WAY_STREAM_ROUND_ROBIN_EN
  assign ptr_d = transfer ? grant_idx + 3'd1 : ptr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_select = out_select_q;

endmodule

// File: tb/tb_mux8way_stream.sv
// Scoreboard bench for mux8way_stream: directed stimulus pushes expected words, a monitor pops
// and compares each word the consumer takes. Expectations follow MUX8WAY_STREAM_ROUND_ROBIN_EN.
module tb_mux8way_stream;

  localparam int unsigned W = 16;

  logic           clock;
  logic           reset_n;
  logic [7:0]     in_valid;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_select;
  logic           out_ready;

  typedef struct packed {
    logic [W-1:0] data;
    logic [2:0]   sel;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  mux8way_stream #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_select (out_select),
    .out_ready  (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] v, input logic ordy);
    @(negedge clock);
    in_valid  = v;
    out_ready = ordy;
    #1;
  endtask

  task automatic push(input logic [2:0] ch);
    exp_t e;
    e.sel  = ch;
    e.data = {8'hA0, 1'b0, ch, 4'h0};
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clock);
    in_valid  = 8'h00;
    out_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
  endtask

  // Monitor: a word is consumed on the next edge whenever valid and ready are both high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (reset_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_word", {13'd0, out_select, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("sb_data", 32'(out_data), 32'(e.data));
          check("sb_select", 32'(out_select), 32'(e.sel));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g;
    logic [2:0] held;
    reset_n   = 1'b0;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*W +: W] = {8'hA0, 4'(i), 4'h0};

    // Reset holds everything low, both before and after a clock edge.
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h00);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_select", 32'(out_select), 32'h0);
    @(posedge clock);
    #2;
    check("rst_in_ready_edge", 32'(in_ready), 32'h00);
    check("rst_out_valid_edge", 32'(out_valid), 32'h0);
    check("rst_out_data_edge", 32'(out_data), 32'h0);
    @(negedge clock);
    in_valid = 8'h00;
    #1 reset_n = 1'b1;

    // Single channel 3.
    in_data[3*W +: W] = 16'h1234;
    drive(8'b0000_1000, 1'b1);
    check("single_ready", 32'(in_ready), 32'h08);
    sb_q.push_back('{data: 16'h1234, sel: 3'd3});
    drive(8'h00, 1'b1);
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_data", 32'(out_data), 32'h1234);
    check("single_select", 32'(out_select), 32'h3);
    in_data[3*W +: W] = 16'hA030;

    // All channels valid: rotation 0..7,0 (or channel 0 forever under fixed priority).
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(8'hFF, 1'b1);
`ifdef MUX8WAY_STREAM_ROUND_ROBIN_EN
      g = 3'(k % 8);
`else
      g = 3'd0;
`endif
      check("rr_ready", 32'(in_ready), 32'(8'h01 << g));
      push(g);
    end

    // Grant 6, then 0 beats 2.
    drive(8'b0100_0000, 1'b1);
    check("g6_ready", 32'(in_ready), 32'h40);
    push(3'd6);
    drive(8'b0000_0101, 1'b1);
    check("wrap_ready0", 32'(in_ready), 32'h01);
    push(3'd0);
    drive(8'b0000_0100, 1'b1);
    check("wrap_ready2", 32'(in_ready), 32'h04);
    push(3'd2);
    drive(8'h00, 1'b1);

    // Backpressure with all channels valid.
`ifdef MUX8WAY_STREAM_ROUND_ROBIN_EN
    held = 3'd3;
`else
    held = 3'd0;
`endif
    drive(8'hFF, 1'b1);
    check("bp_first_ready", 32'(in_ready), 32'(8'h01 << held));
    push(held);
    for (int k = 0; k < 4; k++) begin
      drive(8'hFF, 1'b0);
      check("bp_ready", 32'(in_ready), 32'h00);
      check("bp_data", 32'(out_data), 32'({8'hA0, 1'b0, held, 4'h0}));
      check("bp_select", 32'(out_select), 32'(held));
    end
`ifdef MUX8WAY_STREAM_ROUND_ROBIN_EN
    g = 3'd4;
`else
    g = 3'd0;
`endif
    drive(8'hFF, 1'b1);
    check("bp_resume_ready", 32'(in_ready), 32'(8'h01 << g));
    push(g);
    drive(8'h00, 1'b1);

    // Mid-operation reset discards the held word from channel 5.
    drive(8'b0010_0000, 1'b1);
    check("mid_ready5", 32'(in_ready), 32'h20);
    push(3'd5);
    drive(8'h00, 1'b0);
    check("mid_held_valid", 32'(out_valid), 32'h1);
    check("mid_held_select", 32'(out_select), 32'h5);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_select", 32'(out_select), 32'h0);
    void'(sb_q.pop_back());
    #1 reset_n = 1'b1;
    drive(8'b1000_0010, 1'b1);
    check("mid_after_ready", 32'(in_ready), 32'h02);
    push(3'd1);
    drive(8'h00, 1'b1);

    // Eight cycles of all-valid: fixed priority stays on 0, rotation resumes after channel 1.
    for (int k = 0; k < 8; k++) begin
      drive(8'hFF, 1'b1);
`ifdef MUX8WAY_STREAM_ROUND_ROBIN_EN
      g = 3'((2 + k) % 8);
`else
      g = 3'd0;
`endif
      check("prio_ready", 32'(in_ready), 32'(8'h01 << g));
      push(g);
    end
    drive(8'h00, 1'b1);

    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clock);
    check("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux8way_stream.md
# mux8way_stream

Gathers eight valid/ready input channels into one output stream tagged with a 3-bit channel select. This is the collecting counterpart of the `dmux8way` distributor: `dmux8way` takes one input plus a select and drives one of eight outputs; this block takes eight inputs and produces one output plus a select. It contains a round-robin arbiter and a one-entry registered output stage, and sits in the datapath wherever eight producers share one consumer.

## Interface
Parameters:
- `WIDTH`, default 16: data width of each channel and of the output.

Ports:
- `clock`, input, 1: single clock; all state changes on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 8: per-channel valid; bit i belongs to channel i.
- `in_data`, input, 8*WIDTH: channel i occupies `in_data[i*WIDTH +: WIDTH]`.
- `in_ready`, output, 8: per-channel ready; at most one bit is high in any cycle.
- `out_valid`, output, 1: the output register holds a word.
- `out_data`, output, WIDTH: the held word.
- `out_select`, output, 3: index of the channel the held word came from.
- `out_ready`, input, 1: the consumer accepts the word this cycle.

## Operation
- State:
  - output register: `out_valid`, `out_data`, `out_select`.
  - rotating pointer `ptr`, 3 bits, which marks the highest-priority channel.
- The block can accept a word in a cycle when `!out_valid || out_ready`. This lets it refill in the same cycle it drains.
- Grant rule:
  - Search channels `ptr`, `ptr+1`, … `ptr+7` (mod 8). The first channel with `in_valid` set wins.
  - `in_ready[g]` = 1 only for the winning channel g, and only when the block can accept.
  - `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready` and `ptr`.
- A transfer on channel g means `in_valid[g] && in_ready[g]`. On the next edge:
  - `out_data` ← channel g data.
  - `out_select` ← g.
  - `out_valid` ← 1.
  - `ptr` ← g+1 mod 8, so 7 wraps to 0.
- If the output drains (`out_valid && out_ready`) and no channel is valid:
  - `out_valid` ← 0.
  - `out_data` and `out_select` hold their last values.
  - `ptr` is unchanged.
- While `out_valid && !out_ready`:
  - `out_data`, `out_select` and `ptr` are frozen.
  - All `in_ready` bits are 0.
- Producers must hold `in_valid` and `in_data` stable until they see their ready. Deasserting valid early is a protocol violation and its outcome is undefined.

## Timing
- Reset (`reset_n` low, takes effect immediately without waiting for a clock edge):
  - `out_valid`=0, `out_data`=0, `out_select`=0, `ptr`=0.
  - `in_ready` is forced to 8'h00 while `reset_n` is low.
- Reset mid-operation: any held word is discarded with no handshake. After release, the first grant searches from channel 0.
- Latency: a word accepted in cycle N is on `out_*` in cycle N+1.
- Throughput: one word per cycle while `out_ready` stays high.
- Fairness: with all eight channels continuously valid, each channel is granted exactly once in every 8 consecutive transfers.

## Configuration
- `MUX8WAY_STREAM_ROUND_ROBIN_EN`:
  - Defined: the rotating-pointer arbitration described above.
  - Undefined: fixed priority, where the lowest-numbered valid channel always wins. The `ptr` register is not built, and the search always starts at channel 0. All other behaviour, latency and reset values are identical.

## Test plan
- Reset: hold `reset_n`=0 with `in_valid`=8'hFF and `out_ready`=1. Expect `in_ready`=8'h00, `out_valid`=0, `out_data`=16'h0000, `out_select`=3'b000 throughout, including between clock edges.
- Single channel: `in_valid`=8'b0000_1000, channel 3 data 16'h1234, `out_ready`=1. Expect `in_ready`=8'b0000_1000 in the same cycle. On the next cycle expect `out_valid`=1, `out_data`=16'h1234, `out_select`=3'b011.
- Round-robin and wrap: all channels valid continuously, channel i data = 16'hA0i0, `out_ready`=1. Expect `out_select` to sequence 0,1,…,7,0 with one step per cycle. Separately, grant channel 6, then present `in_valid`=8'b0000_0101. Expect channel 0 to be granted before channel 2.
- Backpressure: with a word held, set `out_ready`=0 for 4 cycles while all channels are valid. Expect `out_data` and `out_select` stable and `in_ready`=8'h00. On the cycle `out_ready` returns to 1, expect the next channel in order to be granted in that same cycle.
- Reset mid-operation: with `out_valid`=1 and `out_select`=3'b101, pulse `reset_n` low between clock edges. Expect `out_valid` to go to 0 immediately. After release, with `in_valid`=8'b1000_0010, expect channel 1 to be granted first.
- Macro undefined: `in_valid`=8'hFF held and `out_ready`=1 for 8 cycles. Expect `out_select`=3'b000 on every cycle.
